// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the program-counter sequencing controller.
// Optional misaligned-target trapping is enabled by PC_CTRL_MISALIGN_CHK_EN.
package pc_ctrl_pkg;

    localparam int unsigned PC_AW = 32;
    localparam logic [PC_AW-1:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2,
        ST_RESUME = 2'd3
    } state_e;

    // Numeric order doubles as redirect priority.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JMP  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_TRAP = 2'd3
    } src_e;

    function automatic logic is_misaligned(src_e src, logic [PC_AW-1:0] target);
        return ((src == SRC_BR) || (src == SRC_JMP)) && (target[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// Request/response bundle between the pipeline stages, the PC and pc_ctrl.
// misalign_o exists only when PC_CTRL_MISALIGN_CHK_EN is defined.
interface pc_ctrl_if;
    import pc_ctrl_pkg::*;

    logic [PC_AW-1:0] pc_i;
    logic             br_req_i;
    logic [PC_AW-1:0] br_target_i;
    logic             jmp_req_i;
    logic [PC_AW-1:0] jmp_target_i;
    logic             trap_req_i;
    logic             stall_req_i;
    logic             halt_req_i;
    logic             resume_i;
    logic [PC_AW-1:0] resume_pc_i;
    logic [PC_AW-1:0] new_pc_o;
    logic             change_pc_o;
    logic             halt_o;
    logic             flush_if_o;
    logic             flush_id_o;
    logic [PC_AW-1:0] epc_o;
    logic [1:0]       state_o;
`ifdef PC_CTRL_MISALIGN_CHK_EN
    logic             misalign_o;
`endif

    modport slave (
        input  pc_i, br_req_i, br_target_i, jmp_req_i, jmp_target_i, trap_req_i,
               stall_req_i, halt_req_i, resume_i, resume_pc_i,
        output new_pc_o, change_pc_o, halt_o, flush_if_o, flush_id_o, epc_o, state_o
`ifdef PC_CTRL_MISALIGN_CHK_EN
        , output misalign_o
`endif
    );

    modport master (
        output pc_i, br_req_i, br_target_i, jmp_req_i, jmp_target_i, trap_req_i,
               stall_req_i, halt_req_i, resume_i, resume_pc_i,
        input  new_pc_o, change_pc_o, halt_o, flush_if_o, flush_id_o, epc_o, state_o
`ifdef PC_CTRL_MISALIGN_CHK_EN
        , input misalign_o
`endif
    );

endinterface

// File: rtl/pc_redirect_sel.sv
// Combinational trap > branch > jump priority selector; used for both the live
// request set and the pending request replayed at the end of a stall.
module pc_redirect_sel
    import pc_ctrl_pkg::*;
#(
    parameter logic [PC_AW-1:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
    input  logic             trap_req,
    input  logic             br_req,
    input  logic [PC_AW-1:0] br_target,
    input  logic             jmp_req,
    input  logic [PC_AW-1:0] jmp_target,
    output src_e             src,
    output logic [PC_AW-1:0] target,
    output logic             flush_if,
    output logic             flush_id
);

    always_comb begin
        src      = SRC_NONE;
        target   = '0;
        flush_if = 1'b0;
        flush_id = 1'b0;
        if (trap_req) begin
            src      = SRC_TRAP;
            target   = TRAP_VEC;
            flush_if = 1'b1;
            flush_id = 1'b1;
        end else if (br_req) begin
            src      = SRC_BR;
            target   = br_target;
            flush_if = 1'b1;
            flush_id = 1'b1;
        end else if (jmp_req) begin
            src      = SRC_JMP;
            target   = jmp_target;
            flush_if = 1'b1;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// PC sequencing controller: redirect arbitration, stall-by-reload, halt/resume.
// Define PC_CTRL_MISALIGN_CHK_EN to turn misaligned branch/jump targets into traps.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [PC_AW-1:0] TRAP_VEC = TRAP_VEC_DEFAULT,
    parameter int unsigned      AW       = PC_AW
) (
    input logic      clk,
    input logic      rst_n,
    pc_ctrl_if.slave bus
);

    state_e          state_q, state_d;
    src_e            pend_src_q, pend_src_d;
    logic [AW-1:0]   pend_tgt_q, pend_tgt_d;
    logic [AW-1:0]   epc_q, epc_d;
    logic [AW-1:0]   resume_pc_q, resume_pc_d;
    logic            resume_fire_q, resume_fire_d;
    logic            halt_q;

    src_e            live_src, merged_src, pend_sel_src;
    logic [AW-1:0]   live_tgt, merged_tgt, pend_sel_tgt;
    logic            live_fif, live_fid, pend_fif, pend_fid;
    logic            live_mis, pend_mis, latch_new;

    pc_redirect_sel #(.TRAP_VEC(TRAP_VEC)) u_live_sel (
        .trap_req   (bus.trap_req_i),
        .br_req     (bus.br_req_i),
        .br_target  (bus.br_target_i),
        .jmp_req    (bus.jmp_req_i),
        .jmp_target (bus.jmp_target_i),
        .src        (live_src),
        .target     (live_tgt),
        .flush_if   (live_fif),
        .flush_id   (live_fid)
    );

    // A request seen in HOLD only displaces a strictly lower-priority pending one.
    assign latch_new  = (live_src > pend_src_q);
    assign merged_src = latch_new ? live_src : pend_src_q;
    assign merged_tgt = latch_new ? live_tgt : pend_tgt_q;

    pc_redirect_sel #(.TRAP_VEC(TRAP_VEC)) u_pend_sel (
        .trap_req   (merged_src == SRC_TRAP),
        .br_req     (merged_src == SRC_BR),
        .br_target  (merged_tgt),
        .jmp_req    (merged_src == SRC_JMP),
        .jmp_target (merged_tgt),
        .src        (pend_sel_src),
        .target     (pend_sel_tgt),
        .flush_if   (pend_fif),
        .flush_id   (pend_fid)
    );

`ifdef PC_CTRL_MISALIGN_CHK_EN
    assign live_mis = is_misaligned(live_src, live_tgt);
    assign pend_mis = is_misaligned(pend_sel_src, pend_sel_tgt);
`else
    assign live_mis = 1'b0;
    assign pend_mis = 1'b0;
`endif

    always_comb begin
        bus.change_pc_o = 1'b0;
        bus.new_pc_o    = '0;
        bus.flush_if_o  = 1'b0;
        bus.flush_id_o  = 1'b0;
`ifdef PC_CTRL_MISALIGN_CHK_EN
        bus.misalign_o  = 1'b0;
`endif
        state_d       = state_q;
        pend_src_d    = pend_src_q;
        pend_tgt_d    = pend_tgt_q;
        epc_d         = epc_q;
        resume_pc_d   = resume_pc_q;
        resume_fire_d = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (bus.halt_req_i) begin
                    state_d = ST_HALTED;
                end else if (resume_fire_q) begin
                    bus.change_pc_o = 1'b1;
                    bus.new_pc_o    = resume_pc_q;
                    bus.flush_if_o  = 1'b1;
                end else if (live_src != SRC_NONE) begin
                    bus.change_pc_o = 1'b1;
                    bus.new_pc_o    = live_mis ? TRAP_VEC : live_tgt;
                    bus.flush_if_o  = live_fif;
                    bus.flush_id_o  = live_fid | live_mis;
`ifdef PC_CTRL_MISALIGN_CHK_EN
                    bus.misalign_o  = live_mis;
`endif
                    if (live_mis || (live_src == SRC_TRAP)) epc_d = bus.pc_i;
                end else if (bus.stall_req_i) begin
                    bus.change_pc_o = 1'b1;
                    bus.new_pc_o    = bus.pc_i;
                    state_d         = ST_HOLD;
                end
            end
            ST_HOLD: begin
                bus.change_pc_o = 1'b1;
                bus.new_pc_o    = bus.pc_i;
                if (bus.halt_req_i) begin
                    state_d    = ST_HALTED;
                    pend_src_d = SRC_NONE;
                end else begin
                    if (latch_new) begin
                        pend_src_d = live_src;
                        pend_tgt_d = live_tgt;
                        if (live_src == SRC_TRAP) epc_d = bus.pc_i;
                    end
                    if (!bus.stall_req_i) begin
                        state_d         = ST_RUN;
                        pend_src_d      = SRC_NONE;
                        bus.change_pc_o = (pend_sel_src != SRC_NONE);
                        bus.new_pc_o    = pend_mis ? TRAP_VEC : pend_sel_tgt;
                        bus.flush_if_o  = pend_fif;
                        bus.flush_id_o  = pend_fid | pend_mis;
`ifdef PC_CTRL_MISALIGN_CHK_EN
                        bus.misalign_o  = pend_mis;
`endif
                        if (pend_mis) epc_d = bus.pc_i;
                    end
                end
            end
            ST_HALTED: begin
                if (bus.resume_i) begin
                    state_d     = ST_RESUME;
                    resume_pc_d = bus.resume_pc_i;
                end
            end
            ST_RESUME: begin
                state_d       = ST_RUN;
                resume_fire_d = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pend_src_q    <= SRC_NONE;
            pend_tgt_q    <= '0;
            epc_q         <= '0;
            resume_pc_q   <= '0;
            resume_fire_q <= 1'b0;
            halt_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_src_q    <= pend_src_d;
            pend_tgt_q    <= pend_tgt_d;
            epc_q         <= epc_d;
            resume_pc_q   <= resume_pc_d;
            resume_fire_q <= resume_fire_d;
            halt_q        <= (state_d == ST_HALTED);
        end
    end

    assign bus.halt_o  = halt_q;
    assign bus.epc_o   = epc_q;
    assign bus.state_o = state_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed literal checks plus randomized traffic
// against a cycle-level behavioural model; honours PC_CTRL_MISALIGN_CHK_EN.
module tb_pc_ctrl;

    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int RUN = 0, HOLD = 1, HALTED = 2, RESUME = 3;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    pc_ctrl_if bus ();

    pc_ctrl #(.TRAP_VEC(TV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_state;
    int          m_pend_pri;
    logic [31:0] m_pend_tgt, m_epc, m_resume_pc;
    bit          m_halt, m_resume_fire;
    bit          e_chg, e_fif, e_fid, e_mis;
    logic [31:0] e_new;

    function automatic logic [31:0] target_of(input int pri, input logic [31:0] bt,
                                              input logic [31:0] jt);
        return (pri == 3) ? TV : (pri == 2) ? bt : jt;
    endfunction

    task automatic issue(input int pri, input logic [31:0] tgt, output bit conv);
        int          p = pri;
        logic [31:0] t = tgt;
        conv = 1'b0;
`ifdef PC_CTRL_MISALIGN_CHK_EN
        if ((p == 1 || p == 2) && t[1:0] != 2'b00) begin
            p    = 3;
            t    = TV;
            conv = 1'b1;
        end
`endif
        e_chg = 1'b1;
        e_new = t;
        e_fif = 1'b1;
        e_fid = (p >= 2);
        e_mis = conv;
    endtask

    always @(negedge clk) begin : model
        int          lp, nxt, npri;
        logic [31:0] lt, pc, ntgt, nepc;
        bit          conv;
        if (!rst_n) begin
            m_state = RUN; m_pend_pri = 0; m_pend_tgt = '0; m_epc = '0;
            m_resume_pc = '0; m_halt = 1'b0; m_resume_fire = 1'b0;
        end else begin
            e_chg = 0; e_new = '0; e_fif = 0; e_fid = 0; e_mis = 0;
            pc   = bus.pc_i;
            lp   = bus.trap_req_i ? 3 : bus.br_req_i ? 2 : bus.jmp_req_i ? 1 : 0;
            lt   = target_of(lp, bus.br_target_i, bus.jmp_target_i);
            nxt  = m_state; npri = m_pend_pri; ntgt = m_pend_tgt; nepc = m_epc;
            case (m_state)
                RUN: begin
                    if (bus.halt_req_i) nxt = HALTED;
                    else if (m_resume_fire) begin
                        e_chg = 1; e_new = m_resume_pc; e_fif = 1;
                    end else if (lp != 0) begin
                        issue(lp, lt, conv);
                        if (lp == 3 || conv) nepc = pc;
                    end else if (bus.stall_req_i) begin
                        e_chg = 1; e_new = pc; nxt = HOLD;
                    end
                end
                HOLD: begin
                    e_chg = 1; e_new = pc;
                    if (bus.halt_req_i) begin
                        nxt = HALTED; npri = 0;
                    end else begin
                        if (lp > m_pend_pri) begin
                            npri = lp; ntgt = lt;
                            if (lp == 3) nepc = pc;
                        end
                        if (!bus.stall_req_i) begin
                            nxt = RUN;
                            e_chg = 0; e_new = '0;
                            if (npri != 0) begin
                                issue(npri, ntgt, conv);
                                if (conv) nepc = pc;
                            end
                            npri = 0;
                        end
                    end
                end
                HALTED: begin
                    if (bus.resume_i) begin
                        nxt = RESUME; m_resume_pc = bus.resume_pc_i;
                    end
                end
                default: nxt = RUN;
            endcase
            chk("change_pc", {31'd0, bus.change_pc_o}, {31'd0, e_chg});
            chk("new_pc", bus.new_pc_o, e_new);
            chk("flush_if", {31'd0, bus.flush_if_o}, {31'd0, e_fif});
            chk("flush_id", {31'd0, bus.flush_id_o}, {31'd0, e_fid});
            chk("halt", {31'd0, bus.halt_o}, {31'd0, m_halt});
            chk("epc", bus.epc_o, m_epc);
            chk("state", {30'd0, bus.state_o}, m_state);
`ifdef PC_CTRL_MISALIGN_CHK_EN
            chk("misalign", {31'd0, bus.misalign_o}, {31'd0, e_mis});
`endif
            m_resume_fire = (m_state == RESUME);
            m_halt        = (nxt == HALTED);
            m_state       = nxt;
            m_pend_pri    = npri;
            m_pend_tgt    = ntgt;
            m_epc         = nepc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        bus.br_req_i = 0; bus.jmp_req_i = 0; bus.trap_req_i = 0; bus.stall_req_i = 0;
        bus.halt_req_i = 0; bus.resume_i = 0;
        bus.br_target_i = '0; bus.jmp_target_i = '0; bus.resume_pc_i = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] t = $urandom;
        if ($urandom_range(3) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    task automatic rnd_inputs();
        bus.pc_i         = $urandom & 32'hFFFF_FFFC;
        bus.trap_req_i   = ($urandom_range(99) < 5);
        bus.br_req_i     = ($urandom_range(99) < 20);
        bus.jmp_req_i    = ($urandom_range(99) < 20);
        bus.stall_req_i  = ($urandom_range(99) < 45);
        bus.halt_req_i   = ($urandom_range(99) < 4);
        bus.resume_i     = ($urandom_range(99) < 25);
        bus.br_target_i  = rnd_tgt();
        bus.jmp_target_i = rnd_tgt();
        bus.resume_pc_i  = rnd_tgt();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.pc_i = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #2;
        chk("rst_state", {30'd0, bus.state_o}, 32'd0);
        chk("rst_halt", {31'd0, bus.halt_o}, 32'd0);
        chk("rst_change", {31'd0, bus.change_pc_o}, 32'd0);
        chk("rst_new_pc", bus.new_pc_o, 32'd0);
        chk("rst_epc", bus.epc_o, 32'd0);

        cyc(); bus.pc_i = 32'h10; bus.br_req_i = 1; bus.br_target_i = 32'h40; #2;
        chk("br_change", {31'd0, bus.change_pc_o}, 32'd1);
        chk("br_new_pc", bus.new_pc_o, 32'h40);
        chk("br_flush_if", {31'd0, bus.flush_if_o}, 32'd1);
        chk("br_flush_id", {31'd0, bus.flush_id_o}, 32'd1);

        cyc(); idle_inputs(); bus.pc_i = 32'h20;
        bus.trap_req_i = 1; bus.br_req_i = 1; bus.jmp_req_i = 1;
        bus.br_target_i = 32'h44; bus.jmp_target_i = 32'h48; #2;
        chk("trap_new_pc", bus.new_pc_o, 32'h100);
        cyc(); idle_inputs(); bus.pc_i = 32'h100; #2;
        chk("trap_epc", bus.epc_o, 32'h20);

        cyc(); bus.pc_i = 32'h30; bus.stall_req_i = 1; #2;
        chk("stall0_new_pc", bus.new_pc_o, 32'h30);
        cyc(); bus.jmp_req_i = 1; bus.jmp_target_i = 32'h80; #2;
        chk("stall1_state", {30'd0, bus.state_o}, 32'd1);
        chk("stall1_new_pc", bus.new_pc_o, 32'h30);
        cyc(); idle_inputs(); bus.stall_req_i = 1; bus.br_req_i = 1;
        bus.br_target_i = 32'h90; #2;
        chk("stall2_new_pc", bus.new_pc_o, 32'h30);
        cyc(); idle_inputs(); #2;
        chk("release_new_pc", bus.new_pc_o, 32'h90);
        chk("release_flush_id", {31'd0, bus.flush_id_o}, 32'd1);
        cyc(); #2;
        chk("release_state", {30'd0, bus.state_o}, 32'd0);

        cyc(); bus.halt_req_i = 1; #2;
        cyc(); bus.halt_req_i = 0; #2;
        chk("halt_o", {31'd0, bus.halt_o}, 32'd1);
        chk("halted_state", {30'd0, bus.state_o}, 32'd2);
        cyc(); bus.resume_i = 1; bus.resume_pc_i = 32'h200; #2;
        cyc(); bus.resume_i = 0; bus.resume_pc_i = '0; #2;
        chk("resume_halt_o", {31'd0, bus.halt_o}, 32'd0);
        chk("resume_state", {30'd0, bus.state_o}, 32'd3);
        cyc(); #2;
        chk("resume_change", {31'd0, bus.change_pc_o}, 32'd1);
        chk("resume_new_pc", bus.new_pc_o, 32'h200);
        chk("resume_flush_if", {31'd0, bus.flush_if_o}, 32'd1);

`ifdef PC_CTRL_MISALIGN_CHK_EN
        cyc(); bus.pc_i = 32'h50; bus.jmp_req_i = 1; bus.jmp_target_i = 32'h42; #2;
        chk("mis_new_pc", bus.new_pc_o, 32'h100);
        chk("mis_pulse", {31'd0, bus.misalign_o}, 32'd1);
        cyc(); idle_inputs(); #2;
        chk("mis_clear", {31'd0, bus.misalign_o}, 32'd0);
        chk("mis_epc", bus.epc_o, 32'h50);
`endif

        for (int i = 0; i < 3000; i++) begin
            cyc();
            rnd_inputs();
            if (i == 1500) begin
                #1 rst_n = 1'b0;
                @(negedge clk);
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end

        cyc();
        idle_inputs();
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Sequencing controller for the program counter.
- Arbitrates the redirect sources (trap, EX branch, ID jump), stall requests and halt/resume, then drives the PC's new_pc/change_pc/halt inputs and pipeline flushes.
- Implements stall by re-loading the current PC, because the PC's halt input restarts fetch from address 0.
- Sits between the decode/execute stages and the PC.

Parameters:
- TRAP_VEC, 32'h0000_0100, redirect target on trap_req_i.
- AW, 32, address width; fixed at 32 for this core.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- pc_i  in  32  current PC value (PC's i_addr_o)
- br_req_i  in  1  EX-stage taken branch
- br_target_i  in  32  branch target
- jmp_req_i  in  1  ID-stage jump
- jmp_target_i  in  32  jump target
- trap_req_i  in  1  trap/exception request
- stall_req_i  in  1  hazard or memory-wait stall
- halt_req_i  in  1  halt request (single-cycle pulse or level)
- resume_i  in  1  leave HALTED
- resume_pc_i  in  32  restart address after resume
- new_pc_o  out  32  to PC new_pc_i
- change_pc_o  out  1  to PC change_pc_i
- halt_o  out  1  to PC halt_i
- flush_if_o  out  1  kill the IF/ID instruction
- flush_id_o  out  1  kill the ID/EX instruction
- epc_o  out  32  PC captured at the last trap
- state_o  out  2  current FSM state (debug)

Behaviour:
- Reset values:
  - state = RUN.
  - halt_o, change_pc_o, flush_if_o, flush_id_o = 0.
  - new_pc_o = 0, epc_o = 0.
  - Pending-redirect register is invalid.
- State encoding: RUN = 0, HOLD = 1, HALTED = 2, RESUME = 3. Transitions take effect on posedge clk.
- Redirect priority: trap > branch > jump. Target is TRAP_VEC, br_target_i or jmp_target_i respectively.
- Redirect outputs are combinational:
  - A request in cycle N drives change_pc_o = 1 and new_pc_o = target in cycle N.
  - The PC holds the target after edge N.
- Flush rules:
  - trap or branch: flush_if_o = 1 and flush_id_o = 1.
  - jump: flush_if_o = 1 only.
- Trap: epc_o <= pc_i at the edge ending the trap cycle.
- RUN:
  - halt_req_i has priority over everything → HALTED.
  - Otherwise a redirect is issued as above and the FSM stays in RUN. A redirect with stall_req_i also high is issued immediately; the redirect wins and no HOLD is entered that cycle.
  - Otherwise stall_req_i → HOLD, driving change_pc_o = 1 and new_pc_o = pc_i this cycle.
- HOLD:
  - Every cycle: change_pc_o = 1, new_pc_o = pc_i (hold).
  - A redirect arriving while in HOLD is latched into the pending register. A later, higher-priority request replaces the pending one; equal or lower priority is ignored. A trap also captures epc.
  - When stall_req_i drops: if pending is valid, drive change_pc_o = 1 with the pending target plus its flushes, clear pending, → RUN. Otherwise → RUN with no change.
  - halt_req_i in HOLD → HALTED and pending is discarded.
- HALTED:
  - halt_o = 1 (registered; asserted from the first cycle after entry).
  - change_pc_o = 0; all redirects and stalls are ignored.
  - resume_i → RESUME; halt_o drops at that edge.
- RESUME:
  - Exactly one cycle; the PC's fetch enable and zero-load take effect.
  - Next cycle: change_pc_o = 1, new_pc_o = resume_pc_i (sampled on entry to RESUME), flush_if_o = 1, → RUN.
- Simultaneous halt_req_i and resume_i in HALTED: resume wins.
- Asynchronous reset mid-operation clears all state, including pending; the next cycle is RUN.
- Address arithmetic: none beyond pass-through; no wrap handling is required.

Optional Feature:
- Macro: PC_CTRL_MISALIGN_CHK_EN
- When defined:
  - A branch or jump target with [1:0] != 0 is converted to a trap: redirect to TRAP_VEC, full flush, epc <= pc_i.
  - Extra output misalign_o pulses 1 for one cycle.
  - Applies equally to pending targets when they are issued.
- When undefined: misalign_o is absent and targets pass through unchecked.

Decomposition:
- Shared package holds:
  - state encodings ST_RUN, ST_HOLD, ST_HALTED, ST_RESUME;
  - redirect source codes SRC_NONE = 0, SRC_JMP = 1, SRC_BR = 2, SRC_TRAP = 3 (numeric order = priority);
  - default TRAP_VEC.
- One natural sub-module: pc_redirect_sel, a combinational priority selector returning source code, target and flush flags. It is reused for both live and pending requests.

Test Plan:
- Reset, then idle: all outputs 0, state_o = 0; the PC increments 0, 4, 8.
- br_req_i = 1 with br_target_i = 32'h40 at pc_i = 32'h10: same cycle change_pc_o = 1, new_pc_o = 32'h40, flush_if_o = 1, flush_id_o = 1.
- trap_req_i, br_req_i and jmp_req_i all high at pc_i = 32'h20: new_pc_o = 32'h100; next cycle epc_o = 32'h20.
- stall_req_i high for 3 cycles at pc_i = 32'h30; jmp (target 32'h80) in stall cycle 1, then br (target 32'h90) in stall cycle 2:
  - new_pc_o = 32'h30 during the stall;
  - on release, new_pc_o = 32'h90 with the branch flushes, → RUN.
- halt_req_i pulse → halt_o = 1 next cycle. Then resume_i with resume_pc_i = 32'h200:
  - halt_o drops;
  - after 1 cycle in RESUME, change_pc_o = 1 and new_pc_o = 32'h200.
- With PC_CTRL_MISALIGN_CHK_EN defined: jmp_target_i = 32'h42 → new_pc_o = 32'h100 and misalign_o = 1 for one cycle.
